// File: rtl/spi_master_apb.sv
// APB-slave SPI master (mode 0): six-register map, one chip-select framed
// transaction of command, optional 24-bit address and up to four data bytes.
module spi_master_apb (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [3:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        spi_clk_o,
  output logic        spi_sdo_o,
  output logic        spi_cs_n_o,
  input  logic        spi_sdi_i
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] cmd_r, addr_r, len_r, wdata_r, rdata_r;
  logic        dir_r, addr_en_r;
  logic [7:0]  clkdiv_r;
  logic [63:0] shreg;
  logic [31:0] rx;
  logic [5:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic        sclk;

  logic        busy, wr_en, start, phase_end;
  logic [2:0]  n_bytes;
  logic [5:0]  data_bits, start_bits;
  logic [31:0] data_left, rx_mask;
  logic [63:0] hdr, frame;

  // Handshake: a write commits at a rising edge with psel & penable & pwrite
  // high; pready is constant 1 so every access completes in its access phase.
  assign busy      = (state != IDLE);
  assign wr_en     = psel_i && penable_i && pwrite_i && !busy;
  assign start     = wr_en && (paddr_i == 4'd5) && pwdata_i[0];
  assign phase_end = (div_cnt == clkdiv_r);

  assign n_bytes    = (len_r[2:0] > 3'd4) ? 3'd4 : len_r[2:0];
  assign data_bits  = {n_bytes, 3'b000};
  assign start_bits = 6'd7 + (pwdata_i[3] ? 6'd24 : 6'd0) + data_bits;
  assign rx_mask    = (data_bits == 6'd32) ? 32'hFFFF_FFFF
                                           : ((32'd1 << data_bits) - 32'd1);

  // Frame is left-justified so the shift register MSB is always the current bit;
  // the CTRL fields come from pwdata because they commit on the same edge.
  assign data_left = pwdata_i[2] ? 32'h0 : (wdata_r << (6'd32 - data_bits));
  assign hdr       = pwdata_i[3] ? {cmd_r[7:0], addr_r[23:0], 32'h0}
                                 : {cmd_r[7:0], 56'h0};
  assign frame     = hdr | ({data_left, 32'h0} >> (pwdata_i[3] ? 7'd32 : 7'd8));

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (phase_end && sclk && (bit_cnt == 6'd0)) state_nxt = HOLD;
      HOLD:    if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_r     <= '0;
      addr_r    <= '0;
      len_r     <= '0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      dir_r     <= 1'b0;
      addr_en_r <= 1'b0;
      clkdiv_r  <= '0;
      shreg     <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      sclk      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (paddr_i)
          4'd0: cmd_r   <= pwdata_i;
          4'd1: addr_r  <= pwdata_i;
          4'd2: len_r   <= pwdata_i;
          4'd3: wdata_r <= pwdata_i;
          4'd5: begin
            dir_r     <= pwdata_i[2];
            addr_en_r <= pwdata_i[3];
            clkdiv_r  <= pwdata_i[15:8];
          end
          default: ;
        endcase
      end
      case (state)
        IDLE: if (start) begin
          shreg   <= frame;
          bit_cnt <= start_bits;
          div_cnt <= '0;
          sclk    <= 1'b0;
          rx      <= '0;
        end
        SHIFT: if (phase_end) begin
          div_cnt <= '0;
          if (!sclk) begin
            sclk <= 1'b1;
            rx   <= {rx[30:0], spi_sdi_i};
          end else begin
            sclk  <= 1'b0;
            shreg <= {shreg[62:0], 1'b0};
            if (bit_cnt != 6'd0) bit_cnt <= bit_cnt - 6'd1;
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        HOLD: if (phase_end) begin
          div_cnt <= '0;
          if (dir_r && (data_bits != 6'd0)) rdata_r <= rx & rx_mask;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prdata_o = '0;
    if (psel_i && !pwrite_i) begin
      case (paddr_i)
        4'd0:    prdata_o = cmd_r;
        4'd1:    prdata_o = addr_r;
        4'd2:    prdata_o = len_r;
        4'd3:    prdata_o = wdata_r;
        4'd4:    prdata_o = rdata_r;
        4'd5:    prdata_o = {16'h0, clkdiv_r, 4'h0, addr_en_r, dir_r, busy, 1'b0};
        default: prdata_o = '0;
      endcase
    end
  end

  assign pready_o   = 1'b1;
  assign spi_clk_o  = sclk;
  assign spi_cs_n_o = !busy;
  assign spi_sdo_o  = (state == SHIFT) && shreg[63];

endmodule

// File: tb/tb_spi_master_apb.sv
// Bench for spi_master_apb: APB driver tasks, mode-0 SPI slave model, and a
// byte-level frame reference model feeding an expected queue.
module tb_spi_master_apb;

  logic        pclk_i = 1'b0;
  logic        rst_i, psel_i, penable_i, pwrite_i;
  logic [3:0]  paddr_i;
  logic [31:0] pwdata_i, prdata_o;
  logic        pready_o, spi_clk_o, spi_sdo_o, spi_cs_n_o, spi_sdi_i;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic        mosi_q[$];
  int          cs_cyc, frames, cs_bad, exp_cyc;
  logic [7:0]  miso_b[8];
  logic [63:0] miso_sh;
  logic [31:0] m_cmd, m_addr, m_len, m_wdata, m_rdata;
  logic        m_ae, m_dir;
  logic [7:0]  m_div;
  logic [31:0] rd;

  spi_master_apb dut (
    .pclk_i(pclk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .spi_clk_o(spi_clk_o),
    .spi_sdo_o(spi_sdo_o), .spi_cs_n_o(spi_cs_n_o), .spi_sdi_i(spi_sdi_i)
  );

  // clock / reset
  initial forever #5 pclk_i = ~pclk_i;

  // SPI slave model (mode 0) and frame monitors
  always @(negedge spi_cs_n_o) begin
    frames = frames + 1;
    for (int i = 0; i < 8; i++) miso_sh[63-8*i -: 8] = miso_b[i];
    spi_sdi_i = miso_sh[63];
  end
  always @(negedge spi_clk_o) if (!spi_cs_n_o) begin
    miso_sh   = {miso_sh[62:0], 1'b0};
    spi_sdi_i = miso_sh[63];
  end
  always @(posedge spi_clk_o) begin
    mosi_q.push_back(spi_sdo_o);
    if (spi_cs_n_o) cs_bad = cs_bad + 1;
  end
  always @(posedge pclk_i) if (!spi_cs_n_o) cs_cyc = cs_cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge pclk_i);
    psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d; penable_i = 1'b0;
    @(negedge pclk_i);
    penable_i = 1'b1;
    @(negedge pclk_i);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge pclk_i);
    psel_i = 1'b1; pwrite_i = 1'b0; paddr_i = a; penable_i = 1'b0;
    #1 d = prdata_o;
    @(negedge pclk_i);
    penable_i = 1'b1;
    @(negedge pclk_i);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  // Reference model: list the frame as bytes, derive read data and frame length.
  task automatic model_frame();
    int n, hdr_bytes;
    logic [31:0] r;
    n = (m_len > 4) ? 4 : int'(m_len);
    exp_q.delete();
    exp_q.push_back(m_cmd[7:0]);
    if (m_ae) for (int i = 2; i >= 0; i--) exp_q.push_back(m_addr[8*i +: 8]);
    hdr_bytes = exp_q.size();
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(m_dir ? 8'h00 : m_wdata[8*i +: 8]);
    if (m_dir && n > 0) begin
      r = 0;
      for (int i = 0; i < n; i++) r = (r << 8) | 32'(miso_b[hdr_bytes + i]);
      m_rdata = r;
    end
    exp_cyc = exp_q.size() * 8 * 2 * (int'(m_div) + 1) + (int'(m_div) + 1);
  endtask

  task automatic start_frame(input logic [31:0] cmd, input logic [31:0] addr,
                             input logic [31:0] len, input logic [31:0] wdata,
                             input logic ae, input logic dir, input logic [7:0] div);
    m_cmd = cmd; m_addr = addr; m_len = len; m_wdata = wdata;
    m_ae = ae; m_dir = dir; m_div = div;
    apb_write(4'd0, cmd);
    apb_write(4'd1, addr);
    apb_write(4'd2, len);
    apb_write(4'd3, wdata);
    model_frame();
    mosi_q.delete();
    cs_cyc = 0; frames = 0; cs_bad = 0;
    apb_write(4'd5, {16'h0, div, 4'h0, ae, dir, 1'b0, 1'b1});
    check("cs_low_after_start", 64'(spi_cs_n_o), 64'd0);
  endtask

  task automatic finish_frame();
    int n, idx;
    logic [7:0] b;
    n = 0;
    while (!spi_cs_n_o && n < 4000) begin
      @(negedge pclk_i);
      n++;
    end
    check("frame_timeout", 64'(n < 4000), 64'd1);
    check("sclk_pulses", 64'(mosi_q.size()), 64'(exp_q.size() * 8));
    idx = 0;
    foreach (exp_q[i]) begin
      b = 0;
      for (int j = 0; j < 8; j++) begin
        b = {b[6:0], (idx < mosi_q.size()) ? mosi_q[idx] : 1'b0};
        idx++;
      end
      check("mosi_byte", 64'(b), 64'(exp_q[i]));
    end
    check("cs_low_cycles", 64'(cs_cyc), 64'(exp_cyc));
    check("frame_count", 64'(frames), 64'd1);
    check("cs_during_sclk", 64'(cs_bad), 64'd0);
    apb_read(4'd4, rd); check("rdata", 64'(rd), 64'(m_rdata));
    apb_read(4'd3, rd); check("wdata_kept", 64'(rd), 64'(m_wdata));
    apb_read(4'd5, rd);
    check("ctrl_idle", 64'(rd), 64'({16'h0, m_div, 4'h0, m_ae, m_dir, 2'b00}));
  endtask

  initial begin
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; spi_sdi_i = 1'b0;
    cs_cyc = 0; frames = 0; cs_bad = 0; m_rdata = 0;
    foreach (miso_b[i]) miso_b[i] = 8'h00;
    repeat (3) @(negedge pclk_i);
    check("rst_sclk", 64'(spi_clk_o), 64'd0);
    check("rst_cs_n", 64'(spi_cs_n_o), 64'd1);
    check("rst_sdo", 64'(spi_sdo_o), 64'd0);
    check("rst_pready", 64'(pready_o), 64'd1);
    check("rst_prdata", 64'(prdata_o), 64'd0);
    rst_i = 1'b0;
    for (int a = 0; a < 6; a++) begin
      apb_read(4'(a), rd);
      check("rst_reg", 64'(rd), 64'd0);
    end

    // register readback and unmapped space
    apb_write(4'd1, 32'habcd1234);
    apb_read(4'd1, rd); check("addr_rb", 64'(rd), 64'habcd1234);
    apb_write(4'd0, 32'hcdef9876);
    apb_read(4'd1, rd); check("addr_kept", 64'(rd), 64'habcd1234);
    apb_read(4'd0, rd); check("cmd_rb", 64'(rd), 64'hcdef9876);
    apb_write(4'd9, 32'h12345678);
    apb_read(4'd9, rd); check("unmapped", 64'(rd), 64'd0);
    apb_write(4'd4, 32'h55aa55aa);
    apb_read(4'd4, rd); check("rdata_ro", 64'(rd), 64'd0);

    // directed write and read transfers
    foreach (miso_b[i]) miso_b[i] = 8'($urandom);
    start_frame(32'h02, 32'h123456, 32'd2, 32'hBEEF, 1'b1, 1'b0, 8'd0);
    finish_frame();
    miso_b[0] = 8'h77; miso_b[1] = 8'hA5; miso_b[2] = 8'h3C;
    start_frame(32'h03, 32'h0, 32'd2, 32'h0, 1'b0, 1'b1, 8'd2);
    finish_frame();
    check("rdata_a53c", 64'(m_rdata), 64'h0000A53C);

    // writes while busy are ignored
    foreach (miso_b[i]) miso_b[i] = 8'($urandom);
    start_frame(32'h9f, 32'habcdef, 32'd4, 32'h11223344, 1'b1, 1'b0, 8'd1);
    apb_write(4'd3, 32'hFFFFFFFF);
    apb_write(4'd5, 32'h0000_0001);
    apb_read(4'd5, rd); check("busy_bit", 64'(rd[1]), 64'd1);
    finish_frame();

    // length clamp and command-only frame
    foreach (miso_b[i]) miso_b[i] = 8'($urandom);
    start_frame(32'h0b, 32'h00ff00, 32'd7, 32'hcafef00d, 1'b1, 1'b1, 8'd0);
    finish_frame();
    start_frame(32'h06, 32'h0, 32'd0, 32'h0, 1'b0, 1'b1, 8'd1);
    finish_frame();

    // randomized transfers
    for (int t = 0; t < 8; t++) begin
      foreach (miso_b[i]) miso_b[i] = 8'($urandom);
      start_frame($urandom, $urandom, 32'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)));
      finish_frame();
    end

    // reset in the middle of a frame
    start_frame(32'h02, 32'h123456, 32'd4, 32'h01020304, 1'b1, 1'b0, 8'd1);
    repeat (20) @(negedge pclk_i);
    rst_i = 1'b1;
    #1;
    check("midrst_cs_n", 64'(spi_cs_n_o), 64'd1);
    check("midrst_sclk", 64'(spi_clk_o), 64'd0);
    check("midrst_sdo", 64'(spi_sdo_o), 64'd0);
    @(negedge pclk_i);
    rst_i = 1'b0;
    apb_read(4'd5, rd); check("midrst_ctrl", 64'(rd), 64'd0);
    apb_read(4'd0, rd); check("midrst_cmd", 64'(rd), 64'd0);
    apb_read(4'd3, rd); check("midrst_wdata", 64'(rd), 64'd0);
    apb_read(4'd4, rd); check("midrst_rdata", 64'(rd), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_apb.md
# spi_master_apb

APB-slave SPI master: software programs a command, an optional 24-bit address and up to 4 data bytes through a six-register APB map, then starts a single chip-select framed SPI transaction. It sits behind the system AHB-to-APB bridge as a zero-wait-state peripheral and drives one external SPI device in mode 0.

## Interface
- No parameters. APB address is a 4-bit word index, data is 32 bits.
- pclk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- psel_i, penable_i, pwrite_i  in  1  APB control.
- paddr_i  in  4  register word index.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data.
- pready_o  out  1  tied 1 (no wait states).
- spi_clk_o  out  1  SCLK, idle low.
- spi_sdo_o  out  1  MOSI.
- spi_cs_n_o  out  1  chip select, active low.
- spi_sdi_i  in  1  MISO.

## Operation
- Register map (index: name): 0 CMD, 1 ADDR, 2 LEN, 3 WDATA, 4 RDATA, 5 CTRL; 6–15 unmapped (read 0, writes ignored).
- CMD, ADDR, LEN, WDATA: full 32-bit read/write storage, reset 0. Only CMD[7:0], ADDR[23:0], LEN[2:0], WDATA[31:0] are used by the transfer.
- RDATA: read-only, reset 0, written only at transfer end.
- CTRL: bit0 START (write 1 starts; reads 0), bit1 BUSY (RO), bit2 DIR (0 = write data phase, 1 = read data phase), bit3 ADDR_EN, bits[15:8] CLKDIV; other bits read 0.
- Write commit: psel_i & penable_i & pwrite_i at a rising edge. While BUSY=1 all writes are ignored (including START).
- Read: prdata_o = selected register, combinationally from paddr_i when psel_i & ~pwrite_i; otherwise 0.
- Frame: CMD[7:0], then ADDR[23:0] if ADDR_EN, then N = min(LEN,4) data bytes; all MSB first.
- Write data phase: sdo shifts WDATA[8N-1:0], MSB first; sdi ignored; RDATA unchanged.
- Read data phase: sdo held 0; 8N sdi bits shifted in MSB first; at end RDATA = received bits right-justified, upper bits 0.
- N=0: command (+ address) only; RDATA is not updated.
- FSM: IDLE -> (START accepted) SHIFT -> (last bit high phase done) HOLD -> (H cycles) IDLE.

## Timing
- Reset values: spi_clk_o 0, spi_cs_n_o 1, spi_sdo_o 0, prdata_o 0, pready_o 1, all registers 0, FSM IDLE.
- H = CLKDIV+1 pclk cycles (half SCLK period); one bit = 2H cycles.
- Cycle after START commit: spi_cs_n_o=0, BUSY=1, spi_sdo_o = first bit, spi_clk_o low.
- Each bit: spi_clk_o low H cycles, then high H cycles. sdi is sampled on the pclk edge where spi_clk_o rises. sdo updates to the next bit on the pclk edge where spi_clk_o falls.
- Total SCLK pulses: 8 + 24·ADDR_EN + 8N.
- After the last high phase: spi_clk_o low, spi_cs_n_o held low H more cycles (HOLD). Then spi_cs_n_o=1, BUSY=0, and RDATA is updated on that same edge.
- A START written in the same cycle BUSY falls is accepted only if committed after BUSY reads 0, i.e. no pipelining.
- Reset mid-transfer: outputs return to reset values immediately; the transfer is aborted.

## Test plan
- Register readback: write ADDR=0xabcd1234 and read it back -> 0xabcd1234. Then write CMD=0xcdef9876 followed immediately by a read of ADDR -> 0xabcd1234. Read CMD -> 0xcdef9876. Read index 9 -> 0.
- Write transfer: CMD=0x02, ADDR=0x123456, LEN=2, WDATA=0xBEEF; CTRL=0x0009 (ADDR_EN, CLKDIV=0) -> 48 SCLK pulses; sdo bytes 02 12 34 56 BE EF; CS low for the whole frame; BUSY ends 1 cycle after the last SCLK fall.
- Read transfer: CMD=0x03, LEN=2, CTRL=0x0205 (DIR, no addr, CLKDIV=2) -> 24 pulses with 3-cycle half periods; SPI model returns A5 3C -> RDATA=0x0000A53C.
- Busy protection: during a transfer, write WDATA=0xFFFFFFFF and CTRL START -> WDATA unchanged, no second frame, BUSY reads 1 until the end.
- LEN=7 clamps to 4 bytes; LEN=0 gives an 8-pulse command-only frame with RDATA unchanged.
- Assert rst_i mid-frame -> cs_n=1, sclk=0, BUSY=0, registers 0.
